conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 4, filters per job (legal 1..4).
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, channels per filter (legal 1..3).
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles spent waiting for mac_done (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  synchronous job cancel.
REQ-008 SHALL have port mac_done  input  1  one-cycle pulse from the MAC datapath when an operation completes.
REQ-009 SHALL have port filter_used  output  2  filter select to the filter mux.
REQ-010 SHALL have port chanel  output  2  channel select to the filter mux.
REQ-011 SHALL have port mac_start  output  1  one-cycle MAC launch pulse.
REQ-012 SHALL have port acc_clear  output  1  clear the accumulator before channel 0 of each filter.
REQ-013 SHALL have port acc_en  output  1  add the current MAC result into the accumulator.
REQ-014 SHALL have port result_valid  output  1  accumulated sum for result_filter is complete.
REQ-015 SHALL have port result_filter  output  2  index of the filter whose result is valid.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-018 SHALL have port error  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, FINISH.
REQ-020 IDLE with start=1 SHALL go to ISSUE on the next cycle with filter_used=0 and chanel=0.
REQ-021 ISSUE SHALL last exactly one cycle, with mac_start=1 and acc_clear=(chanel==0), then go to WAIT.
REQ-022 In WAIT, filter_used and chanel SHALL be held stable and the timeout counter SHALL increment every cycle.
REQ-023 In WAIT, mac_done=1 SHALL assert acc_en in the same cycle (combinational from state and mac_done).
REQ-024 In WAIT, mac_done=1 with chanel==NUM_CHANNELS-1 SHALL also assert result_valid in the same cycle, with result_filter=filter_used.
REQ-025 On mac_done with chanel<NUM_CHANNELS-1: chanel+1, go to ISSUE.
REQ-026 On mac_done with last channel and filter_used<NUM_FILTERS-1: filter_used+1, chanel=0, go to ISSUE.
REQ-027 On mac_done with last channel and last filter: go to FINISH.
REQ-028 FINISH SHALL assert done for one cycle, drive filter_used=0 and chanel=0, then go to IDLE.
REQ-029 A job SHALL issue exactly NUM_FILTERS*NUM_CHANNELS mac_start pulses, ordered channel-fastest.
REQ-030 If the counter reaches TIMEOUT without mac_done, the block SHALL set error=1, go to IDLE the next cycle, and assert no done.
REQ-031 error SHALL clear only on reset or on an accepted start.
REQ-032 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, zero the selects, and assert no done or result_valid; abort SHALL take priority over mac_done and timeout in the same cycle.
REQ-033 start outside IDLE SHALL be ignored; mac_done outside WAIT SHALL be ignored.
REQ-034 The timeout counter SHALL reset to 0 on every entry to WAIT.
REQ-035 mac_start, acc_clear, done, busy, filter_used and chanel SHALL be registered outputs or decoded from the registered state only.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE, filter_used=0, chanel=0, counter=0 and error=0.
REQ-037 While in reset, all pulse outputs and busy SHALL be 0.
REQ-038 Reset asserted mid-job SHALL discard the job; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-039 Full job: start pulse, mac_done 3 cycles after each mac_start -> 12 mac_starts in order (f0c0, f0c1, f0c2, f1c0 ... f3c2); acc_clear on the 4 c0 issues; result_valid 4 times with result_filter 0,1,2,3; one done; busy low afterwards.
REQ-040 Back-to-back: mac_done in the first WAIT cycle every time -> ISSUE/WAIT alternate, job spans 1+12*2+1 cycles from start, done once.
REQ-041 Timeout with TIMEOUT=4: mac_done withheld after the first mac_start -> error=1 after 4 WAIT cycles, IDLE, done=0; a new start clears error.
REQ-042 Abort during f2c1 WAIT, with mac_done in the same cycle -> no acc_en, no result_valid, no done; IDLE with selects 0 next cycle.
REQ-043 Reset mid-job at f1c2 -> all outputs at reset values; start held high during reset is not accepted until rst_n=1.
REQ-044 Parameters NUM_FILTERS=1, NUM_CHANNELS=1 -> single mac_start with acc_clear=1, result_valid with result_filter=0 and acc_en in the same cycle, then done.

Source files
------------

// File: rtl/conv_sequencer.sv
// Convolution job sequencer: walks filters x channels, launching one MAC per
// (filter, channel) pair and flagging the accumulated result per filter.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one-cycle MAC launch for the current filter/channel
// WAIT   | waiting for mac_done, timeout counter running
// FINISH | one-cycle job-complete pulse
module conv_sequencer #(
  parameter int NUM_FILTERS  = 4,
  parameter int NUM_CHANNELS = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mac_done,
  output logic [1:0] filter_used,
  output logic [1:0] chanel,
  output logic       mac_start,
  output logic       acc_clear,
  output logic       acc_en,
  output logic       result_valid,
  output logic [1:0] result_filter,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [1:0] LAST_CH  = 2'(NUM_CHANNELS - 1);
  localparam logic [1:0] LAST_F   = 2'(NUM_FILTERS - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      filter_used <= '0;
      chanel      <= '0;
      wait_cnt    <= '0;
      error       <= 1'b0;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      filter_used <= '0;
      chanel      <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            filter_used <= '0;
            chanel      <= '0;
            error       <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // a completion in the last allowed cycle still wins over the timeout
          if (mac_done) begin
            if (chanel != LAST_CH) begin
              chanel <= chanel + 2'd1;
              state  <= ISSUE;
            end else if (filter_used != LAST_F) begin
              filter_used <= filter_used + 2'd1;
              chanel      <= '0;
              state       <= ISSUE;
            end else begin
              filter_used <= '0;
              chanel      <= '0;
              state       <= FINISH;
            end
          end else if (wait_cnt == TO_LAST) begin
            state       <= IDLE;
            error       <= 1'b1;
            filter_used <= '0;
            chanel      <= '0;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are state decodes, held low while reset is asserted
  assign busy          = rst_n && (state != IDLE);
  assign mac_start     = rst_n && (state == ISSUE);
  assign acc_clear     = mac_start && (chanel == 2'd0);
  assign done          = rst_n && (state == FINISH);
  assign acc_en        = rst_n && (state == WAIT) && mac_done && !abort;
  assign result_valid  = acc_en && (chanel == LAST_CH);
  assign result_filter = filter_used;

endmodule
